game_fsm_ctrl: RTL and testbench

Next-generation game control FSM with built-in round timing. The round timer is generated internally from clkIn, so there is no external timer_expired input. Adds a pre-game countdown, pause/resume, abort, saturating score accumulation and high-score tracking. Sits between the debounced button inputs / hit detector and the display/score driver. Supersedes game_fsm plus the external timer and score counter.

---
 rtl/game_fsm_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_game_fsm_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_fsm_ctrl.sv
// Game round controller: start/pause edge detection, countdown, internal one-second
// round timer, saturating score and high-score tracking for the display/score driver.
module game_fsm_ctrl #(
   parameter int TICKS_PER_SEC     = 100_000_000,
   parameter int GAME_SECONDS      = 30,
   parameter int COUNTDOWN_SECONDS = 3,
   parameter int TIME_W            = 6,
   parameter int SCORE_W           = 6
) (
   input  logic               clkIn,
   input  logic               reset,
   input  logic               startGame,
   input  logic               pauseToggle,
   input  logic               abort,
   input  logic               hit,
   output logic [2:0]         state,
   output logic               game_active,
   output logic [1:0]         countdown,
   output logic [TIME_W-1:0]  time_left,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] high_score,
   output logic               new_high,
   output logic               round_done
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_RUNNING   = 3'd2,
      S_PAUSED    = 3'd3,
      S_FINISH    = 3'd4
   } state_t;

   localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
   localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
   localparam logic [TIME_W-1:0]  GAME_TL    = TIME_W'(GAME_SECONDS);
   localparam logic [TIME_W-1:0]  TL_ONE     = TIME_W'(1);
   localparam logic [1:0]         CD_INIT    = 2'(COUNTDOWN_SECONDS);

   state_t               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [1:0]           cd_q, cd_d;
   logic [TIME_W-1:0]    tl_q, tl_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [SCORE_W-1:0]   hs_q, hs_d;
   logic                 nh_q, nh_d;
   logic                 rd_q, rd_d;
   logic                 start_q, pause_q;
   logic                 start_rise, pause_rise, tick;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      sat_inc = (&v) ? v : v + SCORE_W'(1);
   endfunction

   assign start_rise = startGame & ~start_q;
   assign pause_rise = pauseToggle & ~pause_q;
   assign tick       = (presc_q == PRESC_LAST);

   always_ff @(posedge clkIn or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         cd_q    <= '0;
         tl_q    <= '0;
         score_q <= '0;
         hs_q    <= '0;
         nh_q    <= 1'b0;
         rd_q    <= 1'b0;
         start_q <= 1'b0;
         pause_q <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cd_q    <= cd_d;
         tl_q    <= tl_d;
         score_q <= score_d;
         hs_q    <= hs_d;
         nh_q    <= nh_d;
         rd_q    <= rd_d;
         start_q <= startGame;
         pause_q <= pauseToggle;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      cd_d    = cd_q;
      tl_d    = tl_q;
      score_d = score_q;
      hs_d    = hs_q;
      nh_d    = nh_q;
      rd_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            score_d = '0;
            tl_d    = '0;
            cd_d    = '0;
            nh_d    = 1'b0;
            presc_d = '0;
            if (!abort && start_rise) begin
               if (COUNTDOWN_SECONDS == 0) begin
                  state_d = S_RUNNING;
                  tl_d    = GAME_TL;
               end else begin
                  state_d = S_COUNTDOWN;
                  cd_d    = CD_INIT;
               end
            end
         end

         S_COUNTDOWN: begin
            score_d = '0;
            nh_d    = 1'b0;
            if (abort) begin
               state_d = S_IDLE;
               cd_d    = '0;
               tl_d    = '0;
               presc_d = '0;
            end else if (tick) begin
               presc_d = '0;
               if (cd_q > 2'd1) begin
                  cd_d = cd_q - 2'd1;
               end else begin
                  state_d = S_RUNNING;
                  cd_d    = '0;
                  tl_d    = GAME_TL;
               end
            end else begin
               presc_d = presc_q + PRESC_ONE;
            end
         end

         S_RUNNING: begin
            if (abort) begin
               state_d = S_IDLE;
               score_d = '0;
               tl_d    = '0;
               cd_d    = '0;
               nh_d    = 1'b0;
               presc_d = '0;
            end else if (pause_rise) begin
               // Prescaler keeps its count so the resumed second is not shortened.
               state_d = S_PAUSED;
            end else begin
               if (hit) score_d = sat_inc(score_q);
               if (tick) begin
                  presc_d = '0;
                  if (tl_q > TL_ONE) begin
                     tl_d = tl_q - TL_ONE;
                  end else begin
                     state_d = S_FINISH;
                     tl_d    = '0;
                     rd_d    = 1'b1;
                     // Final score already includes a hit landing on the last tick.
                     if (score_d > hs_q) begin
                        hs_d = score_d;
                        nh_d = 1'b1;
                     end
                  end
               end else begin
                  presc_d = presc_q + PRESC_ONE;
               end
            end
         end

         S_PAUSED: begin
            if (abort) begin
               state_d = S_IDLE;
               score_d = '0;
               tl_d    = '0;
               cd_d    = '0;
               nh_d    = 1'b0;
               presc_d = '0;
            end else if (pause_rise) begin
               state_d = S_RUNNING;
            end
         end

         S_FINISH: begin
            if (abort) begin
               state_d = S_IDLE;
               score_d = '0;
               tl_d    = '0;
               cd_d    = '0;
               nh_d    = 1'b0;
               presc_d = '0;
            end else if (start_rise) begin
               score_d = '0;
               nh_d    = 1'b0;
               presc_d = '0;
               if (COUNTDOWN_SECONDS == 0) begin
                  state_d = S_RUNNING;
                  tl_d    = GAME_TL;
               end else begin
                  state_d = S_COUNTDOWN;
                  cd_d    = CD_INIT;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            score_d = '0;
            tl_d    = '0;
            cd_d    = '0;
            nh_d    = 1'b0;
            presc_d = '0;
         end
      endcase
   end

   assign state       = state_q;
   assign game_active = (state_q == S_RUNNING);
   assign countdown   = cd_q;
   assign time_left   = tl_q;
   assign score       = score_q;
   assign high_score  = hs_q;
   assign new_high    = nh_q;
   assign round_done  = rd_q;

endmodule

// File: tb/tb_game_fsm_ctrl.sv
// Directed bench for game_fsm_ctrl with 4-cycle ticks, 3 s rounds, 2 s countdown, 3-bit score.
module tb_game_fsm_ctrl;

   logic       clkIn = 1'b0;
   logic       reset;
   logic       startGame, pauseToggle, abort, hit;
   logic [2:0] state;
   logic       game_active;
   logic [1:0] countdown;
   logic [5:0] time_left;
   logic [2:0] score;
   logic [2:0] high_score;
   logic       new_high;
   logic       round_done;

   int checks   = 0;
   int failures = 0;

   game_fsm_ctrl #(
      .TICKS_PER_SEC(4),
      .GAME_SECONDS(3),
      .COUNTDOWN_SECONDS(2),
      .TIME_W(6),
      .SCORE_W(3)
   ) dut (
      .clkIn(clkIn),
      .reset(reset),
      .startGame(startGame),
      .pauseToggle(pauseToggle),
      .abort(abort),
      .hit(hit),
      .state(state),
      .game_active(game_active),
      .countdown(countdown),
      .time_left(time_left),
      .score(score),
      .high_score(high_score),
      .new_high(new_high),
      .round_done(round_done)
   );

   always #5 clkIn = ~clkIn;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clkIn);
      #1;
   endtask

   // Starts a round and leaves the bench on the first RUNNING cycle (entry edge + 8).
   task automatic start_round();
      startGame = 1'b1;
      step(1);
      check_val("cd_entry_state", state, 1);
      check_val("cd_entry_score", score, 0);
      check_val("cd_entry_nh", new_high, 0);
      startGame = 1'b0;
      step(8);
      check_val("run_entry_state", state, 2);
      check_val("run_entry_tl", time_left, 3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; startGame = 1'b0; pauseToggle = 1'b0; abort = 1'b0; hit = 1'b0;
      repeat (2) @(posedge clkIn);
      #1;
      check_val("rst_state", state, 0);
      check_val("rst_score", score, 0);
      check_val("rst_hs", high_score, 0);
      check_val("rst_rd", round_done, 0);
      reset = 1'b1;
      step(1);

      // Basic round timing, startGame held high through FINISH
      startGame = 1'b1;
      step(1);
      check_val("c1_state", state, 1);
      check_val("c1_cd", countdown, 2);
      check_val("c1_ga", game_active, 0);
      step(4);
      check_val("c5_cd", countdown, 1);
      check_val("c5_state", state, 1);
      step(4);
      check_val("c9_state", state, 2);
      check_val("c9_tl", time_left, 3);
      check_val("c9_ga", game_active, 1);
      check_val("c9_cd", countdown, 0);
      step(4);
      check_val("c13_tl", time_left, 2);
      step(4);
      check_val("c17_tl", time_left, 1);
      step(4);
      check_val("c21_state", state, 4);
      check_val("c21_rd", round_done, 1);
      check_val("c21_tl", time_left, 0);
      check_val("c21_ga", game_active, 0);
      check_val("c21_nh", new_high, 0);
      step(1);
      check_val("c22_rd", round_done, 0);
      step(5);
      check_val("held_start_state", state, 4);
      startGame = 1'b0;
      step(1);
      check_val("released_start_state", state, 4);

      // Score saturation at 7
      start_round();
      hit = 1'b1;
      step(9);
      hit = 1'b0;
      check_val("sat_score", score, 7);
      check_val("sat_tl", time_left, 1);
      step(3);
      check_val("sat_fin_state", state, 4);
      check_val("sat_fin_rd", round_done, 1);
      check_val("sat_fin_hs", high_score, 7);
      check_val("sat_fin_nh", new_high, 1);

      // Asynchronous reset mid-round
      start_round();
      hit = 1'b1;
      step(2);
      hit = 1'b0;
      check_val("pre_rst_score", score, 2);
      reset = 1'b0;
      #2;
      check_val("async_state", state, 0);
      check_val("async_score", score, 0);
      check_val("async_hs", high_score, 0);
      check_val("async_tl", time_left, 0);
      check_val("async_ga", game_active, 0);
      check_val("async_nh", new_high, 0);
      reset = 1'b1;
      step(1);
      check_val("post_rst_hs", high_score, 0);
      check_val("post_rst_state", state, 0);

      // 4 hits, then a hit coinciding with the final tick
      start_round();
      hit = 1'b1;
      step(4);
      hit = 1'b0;
      check_val("r1_score4", score, 4);
      check_val("r1_tl2", time_left, 2);
      step(7);
      check_val("r1_tl1", time_left, 1);
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      check_val("r1_fin_state", state, 4);
      check_val("r1_fin_score", score, 5);
      check_val("r1_fin_rd", round_done, 1);
      check_val("r1_fin_hs", high_score, 5);
      check_val("r1_fin_nh", new_high, 1);

      // Lower score replay
      start_round();
      check_val("r2_hs_kept", high_score, 5);
      hit = 1'b1;
      step(3);
      hit = 1'b0;
      check_val("r2_score", score, 3);
      step(9);
      check_val("r2_fin_state", state, 4);
      check_val("r2_fin_hs", high_score, 5);
      check_val("r2_fin_nh", new_high, 0);

      // Equal score does not set new_high
      start_round();
      hit = 1'b1;
      step(5);
      hit = 1'b0;
      check_val("r3_score", score, 5);
      step(7);
      check_val("r3_fin_state", state, 4);
      check_val("r3_fin_score", score, 5);
      check_val("r3_fin_hs", high_score, 5);
      check_val("r3_fin_nh", new_high, 0);

      // Pause at time_left=2, prescaler=1
      start_round();
      step(5);
      check_val("pz_pre_tl", time_left, 2);
      pauseToggle = 1'b1;
      step(1);
      check_val("pz_state", state, 3);
      check_val("pz_ga", game_active, 0);
      step(20);
      hit = 1'b1;
      step(1);
      hit = 1'b0;
      step(19);
      check_val("pz_held_state", state, 3);
      check_val("pz_held_tl", time_left, 2);
      check_val("pz_hit_ignored", score, 0);
      pauseToggle = 1'b0;
      step(1);
      check_val("pz_no_rise_state", state, 3);
      pauseToggle = 1'b1;
      step(1);
      pauseToggle = 1'b0;
      check_val("resume_state", state, 2);
      step(2);
      check_val("resume_tl_r2", time_left, 2);
      step(1);
      check_val("resume_tl_r3", time_left, 1);

      // Abort on the final tick
      step(3);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check_val("abort_fin_state", state, 0);
      check_val("abort_fin_rd", round_done, 0);
      check_val("abort_fin_hs", high_score, 5);
      step(1);
      check_val("abort_fin_rd_next", round_done, 0);

      // Abort together with a pause edge while RUNNING
      start_round();
      hit = 1'b1;
      step(2);
      hit = 1'b0;
      check_val("ab_pre_score", score, 2);
      abort = 1'b1;
      pauseToggle = 1'b1;
      step(1);
      check_val("ab_pz_state", state, 0);
      check_val("ab_pz_score", score, 0);
      check_val("ab_pz_tl", time_left, 0);
      check_val("ab_pz_hs", high_score, 5);
      abort = 1'b0;
      pauseToggle = 1'b0;
      step(1);
      check_val("ab_pz_idle", state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
